apb_slave_regfile: RTL and testbench

// - APB3 completer (slave) answering the APB master transfers issued by the team's bus benches.
// - Holds a small register file; register 0 (WAIT_CFG) programs the wait states inserted per access.
// - Sits behind a single APB master: pclk domain only, no CDC.

---
 rtl/apb_slave_regfile.sv | 203 ++++++++++++++++++++
 tb/tb_apb_slave_regfile.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile
//   APB3 completer holding a small 32-bit register file. Register 0
//   (WAIT_CFG, 4 bits) sets how many wait states each access inserts before
//   pready rises. Single pclk domain; synchronous active-low reset.
//
//   Optional feature macro: APB_SLV_PSLVERR_EN
//     defined   : a bad address answers with pslverr=1 alongside pready=1
//     undefined : pslverr stays 0; bad accesses are silently dropped
//
// Ports
//   pclk     in   1        bus clock, rising edge
//   presetn  in   1        synchronous reset, active low
//   psel     in   1        slave select
//   penable  in   1        access phase indicator
//   pwrite   in   1        1 = write, 0 = read
//   paddr    in   ADDR_W   byte address (word aligned)
//   pwdata   in   DATA_W   write data
//   prdata   out  DATA_W   registered read data, valid while pready=1 on reads
//   pready   out  1        registered transfer-complete
//   pslverr  out  1        registered error response, qualified by pready
// ---------------------------------------------------------------------------
module apb_slave_regfile #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-3:0] NUM_REGS_W = (ADDR_W-2)'(NUM_REGS);

`ifdef APB_SLV_PSLVERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [3:0]          cnt_r, cnt_nxt_s;
  logic                pready_r, pready_nxt_s;
  logic [DATA_W-1:0]   prdata_r, prdata_nxt_s;
  logic                pslverr_r, pslverr_nxt_s;
  logic                wr_en_s;
  logic                bad_s;
  logic [ADDR_W-3:0]   idx_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic [3:0]          wait_cfg_s;
  logic [DATA_W-1:0]   regs_r [NUM_REGS];

  // Misaligned or beyond the register file.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-3:0] w;
    w = a[ADDR_W-1:2];
    return (a[1:0] != 2'b00) || (w >= NUM_REGS_W);
  endfunction

  assign idx_s      = paddr[ADDR_W-1:2];
  assign bad_s      = addr_bad(paddr);
  assign wait_cfg_s = regs_r[0][3:0];

  assign prdata  = prdata_r;
  assign pready  = pready_r;
  assign pslverr = pslverr_r;

  // Read mux: addressed word, zero for bad addresses.
  always_comb begin
    rd_word_s = {DATA_W{1'b0}};
    if (!bad_s) begin
      rd_word_s = regs_r[idx_s[IDX_W-1:0]];
    end else begin
      rd_word_s = {DATA_W{1'b0}};
    end
  end

  // Next-state and response logic of the transfer FSM.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    pready_nxt_s  = pready_r;
    prdata_nxt_s  = prdata_r;
    pslverr_nxt_s = pslverr_r;
    wr_en_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (psel && !penable) begin
          cnt_nxt_s = wait_cfg_s;
          if (wait_cfg_s == 4'd0) begin
            // No wait states: response goes out on the SETUP edge.
            state_nxt_s   = ST_READY;
            pready_nxt_s  = 1'b1;
            prdata_nxt_s  = pwrite ? {DATA_W{1'b0}} : rd_word_s;
            pslverr_nxt_s = ERR_EN & bad_s;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          // A stray penable without SETUP lands here and is ignored.
          pready_nxt_s = 1'b0;
        end
      end

      ST_WAIT: begin
        if (!psel) begin
          state_nxt_s   = ST_IDLE;
          pready_nxt_s  = 1'b0;
          prdata_nxt_s  = {DATA_W{1'b0}};
          pslverr_nxt_s = 1'b0;
        end else if (penable) begin
          cnt_nxt_s = cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_nxt_s   = ST_READY;
            pready_nxt_s  = 1'b1;
            prdata_nxt_s  = pwrite ? {DATA_W{1'b0}} : rd_word_s;
            pslverr_nxt_s = ERR_EN & bad_s;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end

      ST_READY: begin
        if (!psel) begin
          // Master abandoned the transfer: no commit.
          state_nxt_s   = ST_IDLE;
          pready_nxt_s  = 1'b0;
          prdata_nxt_s  = {DATA_W{1'b0}};
          pslverr_nxt_s = 1'b0;
        end else if (penable && pready_r) begin
          wr_en_s       = pwrite && !bad_s;
          state_nxt_s   = ST_IDLE;
          pready_nxt_s  = 1'b0;
          prdata_nxt_s  = {DATA_W{1'b0}};
          pslverr_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_READY;
        end
      end

      default: begin
        state_nxt_s   = ST_IDLE;
        cnt_nxt_s     = 4'd0;
        pready_nxt_s  = 1'b0;
        prdata_nxt_s  = {DATA_W{1'b0}};
        pslverr_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state, wait counter and registered bus outputs.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      pready_r  <= 1'b0;
      prdata_r  <= {DATA_W{1'b0}};
      pslverr_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      pready_r  <= pready_nxt_s;
      prdata_r  <= prdata_nxt_s;
      pslverr_r <= pslverr_nxt_s;
    end
  end

  // Register file; WAIT_CFG keeps only its low nibble.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s) begin
      if (idx_s == {(ADDR_W-2){1'b0}}) begin
        regs_r[0] <= {{(DATA_W-4){1'b0}}, pwdata[3:0]};
      end else begin
        regs_r[idx_s[IDX_W-1:0]] <= pwdata;
      end
    end else begin
      regs_r <= regs_r;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: directed scenarios followed by
// randomized transfers, all checked against an array-based register model.
module tb_apb_slave_regfile;

  localparam int NREG = 8;

  logic        pclk;
  logic        presetn;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int total_cnt;
  int bad_cnt;

  logic [31:0] model [NREG];

`ifdef APB_SLV_PSLVERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  apb_slave_regfile #(.ADDR_W(16), .DATA_W(32), .NUM_REGS(NREG)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit is_bad(input logic [15:0] a);
    return ((a % 4) != 0) || ((a / 4) >= NREG);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) model[i] = 32'd0;
  endtask

  // One complete transfer; checks wait count, read data and error flag.
  task automatic apb_xfer(input logic wr, input logic [15:0] addr,
                          input logic [31:0] data, input bit idle_after);
    int          waits;
    int          exp_w;
    bit          bad;
    logic [31:0] exp_rd;
    exp_w  = int'(model[0] % 16);
    bad    = is_bad(addr);
    exp_rd = bad ? 32'd0 : model[addr / 4];
    @(negedge pclk);
    chk("pready_pre", {31'd0, pready}, 32'd0);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(negedge pclk);
    penable = 1'b1;
    waits = 0;
    while (pready !== 1'b1 && waits < 40) begin
      @(negedge pclk);
      waits++;
    end
    chk("waits", waits, exp_w);
    if (!wr) chk("prdata", prdata, exp_rd);
    chk("pslverr", {31'd0, pslverr}, {31'd0, ERR_ON & bad});
    if (wr && !bad) model[addr / 4] = (addr == 16'd0) ? (data & 32'h0000_000F) : data;
    if (idle_after) begin
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] a;
    logic        w;
    logic [31:0] d;
    total_cnt = 0; bad_cnt = 0;
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 16'd0; pwdata = 32'd0;
    model_reset();
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    presetn = 1'b1;

    // T1: reset in the middle of a transfer
    apb_xfer(1'b1, 16'h0004, 32'h1234_5678, 1'b1);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0004; pwdata = 32'h0000_0055;
    @(negedge pclk);
    penable = 1'b1; presetn = 1'b0;
    repeat (2) @(negedge pclk);
    chk("t1_pready", {31'd0, pready}, 32'd0);
    chk("t1_prdata", prdata, 32'd0);
    chk("t1_pslverr", {31'd0, pslverr}, 32'd0);
    model_reset();
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
    chk("t1_stray_penable", {31'd0, pready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    apb_xfer(1'b0, 16'h0004, 32'd0, 1'b1);

    // T2: zero wait states
    apb_xfer(1'b1, 16'h0004, 32'hAAAA_AAAA, 1'b1);
    apb_xfer(1'b0, 16'h0004, 32'd0, 1'b1);

    // T3: three wait states
    apb_xfer(1'b1, 16'h0000, 32'h0000_0003, 1'b1);
    apb_xfer(1'b1, 16'h0008, 32'hBBBB_BBBB, 1'b1);
    apb_xfer(1'b0, 16'h0008, 32'd0, 1'b1);

    // T4: WAIT_CFG keeps its low nibble only
    apb_xfer(1'b1, 16'h0000, 32'h0000_0123, 1'b1);
    apb_xfer(1'b0, 16'h0000, 32'd0, 1'b1);

    // T5: back-to-back write then read
    apb_xfer(1'b1, 16'h000C, 32'h0000_0001, 1'b0);
    apb_xfer(1'b0, 16'h000C, 32'd0, 1'b1);

    // T6: bad addresses
    apb_xfer(1'b1, 16'h0020, 32'hDEAD_BEEF, 1'b1);
    apb_xfer(1'b1, 16'h0006, 32'hDEAD_BEEF, 1'b1);
    apb_xfer(1'b0, 16'h0020, 32'd0, 1'b1);
    apb_xfer(1'b0, 16'h0006, 32'd0, 1'b1);
    apb_xfer(1'b0, 16'h0004, 32'd0, 1'b1);

    // psel dropped during wait states: write must not land
    apb_xfer(1'b1, 16'h0000, 32'h0000_0002, 1'b1);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0010; pwdata = 32'h0000_0077;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("drop_pready", {31'd0, pready}, 32'd0);
    apb_xfer(1'b0, 16'h0010, 32'd0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        8:       a = 16'h0020 + 16'($urandom_range(0, 7) * 4);
        9:       a = 16'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
        default: a = 16'($urandom_range(0, 7) * 4);
      endcase
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (a == 16'd0) d = {d[31:4], 4'($urandom_range(0, 4))};
      apb_xfer(w, a, d, 1'($urandom_range(0, 1)));
    end

    // Final sweep of every register
    for (int i = 0; i < NREG; i++) apb_xfer(1'b0, 16'(i * 4), 32'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
